fetch_unit: RTL

- Instruction-fetch stage directly downstream of PC_block; consumes pc_o/pc4_o and issues requests on a req/gnt/rvalid instruction-memory interface.
- Buffers returned instructions with their PC in a small queue, presents them to the IF/ID register via valid/ready, and advances PC only when a fetch is granted.
- Discards in-flight and queued instructions on a taken branch (flush).

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The entry PC fields are FETCH_XLEN wide; fetch_unit's XLEN parameter must match.
package fetch_pkg;

    localparam int          FETCH_XLEN = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]           instr;
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] pc4;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with clear; pointers carry an extra wrap bit
// so that full and empty can be told apart.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t data_i,
    input  logic         pop_i,
    output fetch_entry_t data_o,
    output logic [AW:0]  count_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign count_o = wptr_q - rptr_q;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO is legal when a pop frees the head slot in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, responses buffered with their PC.
// Optional FETCH_BYPASS_EN presents a response in its arrival cycle when the queue is empty.
//   state | meaning
//   IDLE  | first cycle out of reset, late responses ignored
//   REQ   | request pc_i while a queue slot is free
//   WAIT  | one request outstanding, capture its response
//   DRAIN | flushed while outstanding, discard the response
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = FETCH_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc4_i,
    output logic            pc_en_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            id_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] instr_pc4_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [XLEN-1:0] pend_pc4_q, pend_pc4_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic [XLEN-1:0] last_pc4_q, last_pc4_d;

    fetch_entry_t    rsp_entry, head;
    logic [CW-1:0]   count;
    logic            full, empty;
    logic            req, rsp_accept, bypass, pop_ok, fifo_push, fifo_pop;
    logic            out_valid;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc, out_pc4;

    always_comb begin
        state_d    = state_q;
        pend_pc_d  = pend_pc_q;
        pend_pc4_d = pend_pc4_q;
        req        = 1'b0;
        pc_en_o    = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                req = !flush_i && (count < CW'(DEPTH));
                if (req && imem_gnt_i) begin
                    pc_en_o    = 1'b1;
                    pend_pc_d  = pc_i;
                    pend_pc4_d = pc4_i;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i)  state_d = REQ;
                else if (flush_i)   state_d = DRAIN;
            end
            DRAIN: begin
                if (imem_rvalid_i) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_accept = (state_q == WAIT) && imem_rvalid_i && !flush_i;
        rsp_entry  = '{instr: imem_rdata_i, pc: pend_pc_q, pc4: pend_pc4_q};
        bypass     = 1'b0;
`ifdef FETCH_BYPASS_EN
        bypass     = empty && rsp_accept;
`endif
        out_valid = !empty || bypass;
        if (bypass) begin
            out_instr = rsp_entry.instr;
            out_pc    = rsp_entry.pc;
            out_pc4   = rsp_entry.pc4;
        end else if (!empty) begin
            out_instr = head.instr;
            out_pc    = head.pc;
            out_pc4   = head.pc4;
        end else begin
            out_instr = NOP_INSTR;
            out_pc    = last_pc_q;
            out_pc4   = last_pc4_q;
        end
        pop_ok    = out_valid && id_ready_i && !flush_i;
        // A bypassed response consumed by decode never enters the queue.
        fifo_push = rsp_accept && !(bypass && id_ready_i);
        fifo_pop  = pop_ok && !bypass;
        last_pc_d  = last_pc_q;
        last_pc4_d = last_pc4_q;
        if (pop_ok) begin
            last_pc_d  = out_pc;
            last_pc4_d = out_pc4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pend_pc_q  <= '0;
            pend_pc4_q <= '0;
            last_pc_q  <= '0;
            last_pc4_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_pc_q  <= pend_pc_d;
            pend_pc4_q <= pend_pc4_d;
            last_pc_q  <= last_pc_d;
            last_pc4_q <= last_pc4_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .push_i  (fifo_push),
        .data_i  (rsp_entry),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_i;
    assign instr_valid_o = out_valid;
    assign instr_o       = out_instr;
    assign instr_pc_o    = out_pc;
    assign instr_pc4_o   = out_pc4;

endmodule
